// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Request bundle, access-length/state enums and load extension.
package dmem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    LEN_BYTE    = 2'd0,
    LEN_HALF    = 2'd1,
    LEN_WORD    = 2'd2,
    LEN_ILLEGAL = 2'd3
  } len_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  len;
    logic        sign;
  } req_t;

  function automatic logic [31:0] extend(
    input logic [15:0] v,
    input logic        half,
    input logic        sg
  );
    if (half) return {{16{sg & v[15]}}, v};
    return {{24{sg & v[7]}}, v[7:0]};
  endfunction

endpackage

// File: rtl/dmem_if.sv
// MEM-stage to data-memory request/response bundle.
// master = MEM stage, slave = responder.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_length;
  logic        req_sign;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_wr, req_addr,
    output req_wdata, req_length, req_sign,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, busy
  );

  modport slave (
    input  req_valid, req_wr, req_addr,
    input  req_wdata, req_length, req_sign,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, busy
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
// MISALIGN_TRAP_EN: flag misaligned/illegal accesses instead of truncating.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [1:0]  len_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  input  logic        sign_i,
  output logic [3:0]  be_o,
  output logic [31:0] wlane_o,
  output logic [31:0] rdata_o,
  output logic        mis_o
);

  logic [1:0]  a_eff;
  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic [31:0] sh;

  always_comb begin
    a_eff = addr_i;
    is_b  = (len_i == LEN_BYTE);
    is_h  = (len_i == LEN_HALF);
`ifdef MISALIGN_TRAP_EN
    is_w  = (len_i == LEN_WORD);
    mis_o = (is_h && addr_i[0])
          | (is_w && (addr_i != 2'b00))
          | (len_i == LEN_ILLEGAL);
`else
    // Without trapping, the illegal length acts as a word access
    is_w  = (len_i == LEN_WORD) || (len_i == LEN_ILLEGAL);
    mis_o = 1'b0;
    if (is_h) a_eff[0] = 1'b0;
    if (is_w) a_eff = 2'b00;
`endif
  end

  always_comb begin
    be_o    = 4'b0000;
    wlane_o = wdata_i;
    rdata_o = '0;
    sh      = rword_i >> {a_eff, 3'b000};
    if (!mis_o) begin
      unique case (1'b1)
        is_b: begin
          be_o    = 4'b0001 << a_eff;
          wlane_o = {4{wdata_i[7:0]}};
          rdata_o = extend(sh[15:0], 1'b0, sign_i);
        end
        is_h: begin
          be_o    = a_eff[1] ? 4'b1100 : 4'b0011;
          wlane_o = {2{wdata_i[15:0]}};
          rdata_o = extend(sh[15:0], 1'b1, sign_i);
        end
        is_w: begin
          be_o    = 4'b1111;
          rdata_o = rword_i;
        end
        default: be_o = 4'b0000;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder below the MEM stage: one request at a time.
// Optional MISALIGN_TRAP_EN reports misaligned accesses via rsp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e      state_q;
  logic [CW-1:0] cnt_q;
  req_t        req_q;
  logic        ready_q;
  logic        busy_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  req_t        req_in;
  req_t        cur;
  logic        accept;
  logic        fire;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic [31:0] ld_data;
  logic        mis;
  logic        we;
  logic        unused_addr;

  always_comb begin
    req_in.wr    = bus.req_wr;
    req_in.addr  = bus.req_addr;
    req_in.wdata = bus.req_wdata;
    req_in.len   = bus.req_length;
    req_in.sign  = bus.req_sign;
  end

  assign accept = (state_q == IDLE) && bus.req_valid;

  // With LATENCY==1 the access completes on the accepting edge
  assign fire = (accept && (LATENCY == 1))
              | ((state_q == WAIT) && (cnt_q == CW'(1)));

  assign cur = (state_q == IDLE) ? req_in : req_q;
  assign idx = cur.addr[AW+1:2];
  assign unused_addr = ^cur.addr[31:AW+2];

  dmem_lane_align u_align (
    .addr_i  (cur.addr[1:0]),
    .len_i   (cur.len),
    .wdata_i (cur.wdata),
    .rword_i (mem_q[idx]),
    .sign_i  (cur.sign),
    .be_o    (be),
    .wlane_o (wlane),
    .rdata_o (ld_data),
    .mis_o   (mis)
  );

  assign we = fire && cur.wr && !mis && !rst;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            req_q   <= req_in;
            cnt_q   <= CW'(LATENCY - 1);
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
      if (fire) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= cur.wr ? 32'h0 : ld_data;
        rsp_err_q   <= mis;
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder that services load/store requests issued by the RISC-V MEM stage. It accepts one request at a time over a valid/ready handshake and handles byte, half and word accesses with lane merging and sign/zero extension. It waits a programmable access latency, then returns a one-cycle response. It sits directly below the MEM stage, and its ready/busy outputs drive the pipeline stall logic.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two)
LATENCY, 2, cycles from request acceptance to rsp_valid (>=1)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
req_valid  input  1  MEM stage presents a request
req_ready  output  1  responder can accept (IDLE only)
req_wr  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
req_length  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_sign  input  1  load: 1 = sign-extend, 0 = zero-extend
rsp_valid  output  1  one-cycle response strobe
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  misaligned or illegal-length access (valid with rsp_valid)
busy  output  1  request in flight (state != IDLE)

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, state=IDLE. Array contents are not reset.
- States:
  - IDLE: req_ready=1. When req_valid=1, capture all req_* signals, load counter=LATENCY-1, then go to WAIT. If LATENCY==1, go straight to RESP.
  - WAIT: decrement counter each cycle; go to RESP on the edge where counter==1 (counter reaches 0).
  - RESP: rsp_valid=1 for exactly one cycle, then return to IDLE. req_ready stays 0 during this cycle, so back-to-back requests are spaced LATENCY+1 cycles apart.
- rsp_valid rises exactly LATENCY cycles after the accepting edge.
- Array index = captured addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so accesses wrap around the array.
- Store commit: the store is written on the edge entering RESP, using byte-enables.
  - Byte: lane addr[1:0], data wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1}, data wdata[15:0].
  - Word: all four lanes.
  - Unselected bytes are preserved.
- Load: the word is read on the edge entering RESP. The selected lane(s) are shifted to bit 0 and extended per req_sign. Word loads ignore req_sign.
- Misalignment is any of: half with addr[0]=1, word with addr[1:0]!=0, or length=3. On misalignment: no array write, rsp_rdata=0, rsp_err=1.
- Input changes after acceptance are ignored, because all fields are captured.
- Reset mid-operation aborts immediately. A pending store is dropped and no rsp_valid is issued.
- rsp_rdata and rsp_err are registered and return to 0 the cycle after RESP.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: misaligned or illegal-length accesses behave as described above (rsp_err=1, no write).
- Undefined: rsp_err is tied to 0. Address low bits are truncated to the access size (half clears addr[0], word clears addr[1:0]), and the access proceeds normally. Length 3 is treated as word.

Decomposition:
- Package dmem_pkg: length enum LEN_BYTE=2'd0, LEN_HALF=2'd1, LEN_WORD=2'd2, LEN_ILLEGAL=2'd3; state enum IDLE/WAIT/RESP; constant WORD_BYTES=4.
- One combinational sub-module dmem_lane_align. It produces the 4-bit byte-enable and the lane-replicated write data from (addr[1:0], length, wdata). It also extracts and extends load data from (word, addr[1:0], length, sign) and flags misalignment.

Test Plan:
- Store word 0xDEADBEEF at 0x100, LATENCY=2, then load word at 0x100 -> rsp_valid 2 cycles after each accept; load returns 0xDEADBEEF, rsp_err=0.
- After the above, store byte 0x5A at 0x102, then load word at 0x100 -> 0xDE5ABEEF.
- Load byte at 0x103, sign=1 -> 0xFFFFFFDE. Load byte at 0x103, sign=0 -> 0x000000DE. Load half at 0x102, sign=1 -> 0xFFFFDE5A.
- Store half 0x1234 to 0x101 -> with MISALIGN_TRAP_EN: rsp_err=1, word at 0x100 unchanged. Without it: rsp_err=0, word at 0x100 = 0xDE5A1234.
- Hold req_valid=1 continuously with LATENCY=1 -> accepts spaced 2 cycles apart, req_ready=0 during RESP, busy high between accept and RESP.
- Assert rst one cycle after accepting store 0xCAFEF00D to 0x200 -> no rsp_valid, outputs return to reset values; a later load at 0x200 returns the prior contents.
